// File: rtl/seq_mult6.sv
// ---------------------------------------------------------------------------
// seq_mult6 -- 6 x 6 -> 12-bit sequential shift-and-add multiplier.
//
// One partial product is accumulated per clock. A request accepted in IDLE
// produces a one-cycle done pulse and a new product exactly six edges later.
// The following edge returns the FSM to IDLE, so start held high gives one
// multiply every eight cycles.
//
// Build option:
//   SEQ_MULT6_SIGNED_EN  defined   -> a, b and product are two's complement
//                                     (the multiplicand is sign-extended and
//                                     the bit-5 partial product is subtracted)
//                        undefined -> a, b and product are unsigned
//   Cycle timing and the interface are the same in both builds.
//
// Ports:
//   clk      in   1   single clock; all state changes on the rising edge
//   rst      in   1   synchronous active-high reset; overrides everything
//   start    in   1   multiply request; sampled only in IDLE
//   a        in   6   multiplicand, captured on the accepting edge
//   b        in   6   multiplier, captured on the accepting edge
//   busy     out  1   high whenever the FSM is not in IDLE
//   done     out  1   registered one-cycle pulse marking a new product
//                     (load enable for the downstream 12-bit register)
//   product  out  12  registered result of the last completed multiply
// ---------------------------------------------------------------------------
module seq_mult6 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        busy,
  output logic        done,
  output logic [11:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [5:0]  a_q, a_d;
  logic [5:0]  b_q, b_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] product_q, product_d;
  logic        done_q, done_d;

  logic [11:0] a_ext;
  logic [11:0] pp;
  logic [11:0] acc_step;
  logic        cnt_last;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign cnt_last = (cnt_q == 3'd5);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_q != IDLE);
  end

  // -------------------------------------------------------------------------
  // Datapath: one partial product per CALC cycle
  // -------------------------------------------------------------------------
`ifdef SEQ_MULT6_SIGNED_EN
  assign a_ext = {{6{a_q[5]}}, a_q};
`else
  assign a_ext = {6'd0, a_q};
`endif

  assign pp = a_ext << cnt_q;

  always_comb begin
    acc_step = acc_q;
    if (b_q[cnt_q]) begin
`ifdef SEQ_MULT6_SIGNED_EN
      // Bit 5 of a two's complement multiplier carries weight -32.
      if (cnt_last) acc_step = acc_q - pp;
      else          acc_step = acc_q + pp;
`else
      acc_step = acc_q + pp;
`endif
    end
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 3'd1;
        if (cnt_last) begin
          // Final sum goes straight to product, skipping an extra cycle.
          product_d = acc_step;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult6.sv
module tb_seq_mult6;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  int n_assert;
  int n_fail;

  seq_mult6 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start, then follow the operation to completion.
  task automatic run_op(input logic [5:0] ai, input logic [5:0] bi,
                        input logic [11:0] exp, input logic [11:0] prev,
                        input string tag);
    int edges;
    int busy_cnt;
    a = ai; b = bi; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "/busy_accept"}, {11'd0, busy}, 12'd1);
    chk({tag, "/done_accept"}, {11'd0, done}, 12'd0);
    busy_cnt = busy ? 1 : 0;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
      if (done !== 1'b1) chk({tag, "/product_hold"}, product, prev);
    end
    chk({tag, "/latency"}, 12'(edges), 12'd6);
    chk({tag, "/busy_cycles"}, 12'(busy_cnt), 12'd7);
    chk({tag, "/product"}, product, exp);
    tick();
    chk({tag, "/done_clear"}, {11'd0, done}, 12'd0);
    chk({tag, "/busy_clear"}, {11'd0, busy}, 12'd0);
    chk({tag, "/product_keep"}, product, exp);
  endtask

  initial begin
    int edges;
    int pulses;
    logic [11:0] e_m1, e_m2, e_m3, e_bb;

    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

`ifdef SEQ_MULT6_SIGNED_EN
    e_m1 = 12'h400;  // -32 * -32
    e_m2 = 12'hFFF;  // -1 * 1
    e_m3 = 12'hC20;  // 31 * -32
    e_bb = 12'h010;  // 6'd60 is -4; -4 * -4
`else
    e_m1 = 12'h400;  // 32 * 32
    e_m2 = 12'h03F;  // 63 * 1
    e_m3 = 12'h3E0;  // 31 * 32
    e_bb = 12'hE10;  // 60 * 60
`endif

    // Reset state
    tick(); tick();
    chk("reset/busy", {11'd0, busy}, 12'd0);
    chk("reset/done", {11'd0, done}, 12'd0);
    chk("reset/product", product, 12'h000);
    rst = 1'b0;
    tick();
    chk("idle/no_start_busy", {11'd0, busy}, 12'd0);

    // Full-scale unsigned operands (in the signed build -1 * -1 = 1)
`ifdef SEQ_MULT6_SIGNED_EN
    run_op(6'd63, 6'd63, 12'h001, 12'h000, "max");
    run_op(6'd5, 6'd0, 12'h000, 12'h001, "b_zero");
`else
    run_op(6'd63, 6'd63, 12'hF81, 12'h000, "max");
    run_op(6'd5, 6'd0, 12'h000, 12'hF81, "b_zero");
`endif
    run_op(6'd0, 6'd9, 12'h000, 12'h000, "a_zero");
    run_op(6'h20, 6'h20, e_m1, 12'h000, "m1");
    run_op(6'h3F, 6'h01, e_m2, e_m1, "m2");
    run_op(6'h1F, 6'h20, e_m3, e_m2, "m3");

    // Back-to-back with start held high; operands change after acceptance
    a = 6'd7; b = 6'd3; start = 1'b1;
    tick();
    a = 6'd60; b = 6'd60;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    chk("b2b/first_latency", 12'(edges), 12'd6);
    chk("b2b/first_product", product, 12'h015);
    tick();
    chk("b2b/done_idle", {11'd0, done}, 12'd0);
    chk("b2b/busy_idle", {11'd0, busy}, 12'd0);
    tick();
    chk("b2b/reaccept_busy", {11'd0, busy}, 12'd1);
    start = 1'b0;
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    chk("b2b/second_latency", 12'(edges), 12'd6);
    chk("b2b/second_product", product, e_bb);
    tick();

    // Reset three cycles into CALC aborts the operation
    a = 6'd9; b = 6'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort/product", product, 12'h000);
    chk("abort/busy", {11'd0, busy}, 12'd0);
    chk("abort/done", {11'd0, done}, 12'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("abort/no_pulse", 12'(pulses), 12'd0);
    run_op(6'd2, 6'd3, 12'h006, 12'h000, "after_abort");

    // start and operand changes during CALC and DONE are ignored
    a = 6'd5; b = 6'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 6'd1; b = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 2;
    pulses = 0;
    while (done !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    chk("ignore/latency", 12'(edges), 12'd6);
    chk("ignore/product", product, 12'h01E);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignore/done_clear", {11'd0, done}, 12'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) pulses++;
      if (busy === 1'b1) pulses++;
    end
    chk("ignore/no_extra_activity", 12'(pulses), 12'd0);
    chk("ignore/product_keep", product, 12'h01E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult6.md
SEQ_MULT6 -- requirements
Module: seq_mult6

Interface
REQ-001 Parameters: none; widths fixed at 6 x 6 -> 12 bits.
REQ-002 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL provide: a  input  6  multiplicand; captured on the accepting edge.
REQ-006 SHALL provide: b  input  6  multiplier; captured on the accepting edge.
REQ-007 SHALL provide: busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL provide: done  output  1  one-cycle registered pulse marking a new result; drives the ld of the downstream 12-bit register.
REQ-009 SHALL provide: product  output  12  registered result of the last completed multiply.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-011 IDLE with start=1 at an edge SHALL capture a and b, clear the internal accumulator and iteration count (cnt=0), and go to CALC.
REQ-012 IDLE with start=0 SHALL remain in IDLE.
REQ-013 Each CALC edge SHALL add (A << cnt) to the accumulator when B[cnt]=1, add nothing otherwise, and increment cnt.
REQ-014 Accumulator arithmetic SHALL be 12-bit with wrap-around; no overflow is possible for valid operands.
REQ-015 The CALC edge with cnt=5 SHALL load the final sum into product, set done=1, and go to DONE.
REQ-016 Latency: done and the new product SHALL become visible exactly 6 edges after the accepting edge.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally and clear done.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 start SHALL be ignored in CALC and DONE; operands are not re-captured mid-operation.
REQ-020 a and b changes after the accepting edge SHALL NOT affect the result.
REQ-021 product SHALL hold its value between completions and change only on the completing edge.
REQ-022 Back-to-back operation: start held high SHALL be accepted again on the first IDLE edge after DONE, giving an 8-cycle period per multiply.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, cnt=0, accumulator=0, product=12'h000, done=0 and busy=0.
REQ-024 rst SHALL take priority over start and over any in-progress CALC/DONE activity.
REQ-025 rst asserted mid-CALC SHALL abort the operation with no done pulse and product=0.
REQ-026 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Configuration
REQ-027 Macro SEQ_MULT6_SIGNED_EN SHALL select the operand interpretation.
REQ-028 With SEQ_MULT6_SIGNED_EN defined:
- a and b are two's complement.
- Partial products are sign-extended to 12 bits.
- The cnt=5 partial product is subtracted instead of added.
- product is the 12-bit two's complement result.
REQ-029 Without SEQ_MULT6_SIGNED_EN: a, b and product are unsigned.
REQ-030 Cycle timing and the interface SHALL be identical in both builds.

Verification
REQ-031 Unsigned build: a=63, b=63, one-cycle start -> busy high 7 cycles, done pulse 6 edges after accept, product=12'hF81.
REQ-032 Unsigned build: a=5, b=0 -> product=12'h000 with done pulse; then a=0, b=9 -> product=12'h000.
REQ-033 Signed build:
- a=-32, b=-32 -> product=12'h400.
- a=-1, b=1 -> 12'hFFF.
- a=31, b=-32 -> 12'hC20.
REQ-034 Start accepted with a=7, b=3; on the next edge change to a=60, b=60 with start held high -> first product=12'h015, second accepted exactly 8 edges after the first, product=12'hE10.
REQ-035 rst pulsed 3 cycles into CALC -> no done pulse, product=0, busy=0; next start with a=2, b=3 -> product=12'h006.
REQ-036 start pulsed during CALC and DONE -> ignored: exactly one done pulse, result from the originally captured operands.
